accumulator_bank: RTL
=====================

# accumulator_bank

Synaptic accumulator bank directly downstream of the 256-input layer sequencer. It takes one presynaptic spike bit per cycle and one packed weight word holding one weight per postsynaptic neuron. When the spike is 1, it adds each neuron's weight into that neuron's running sum. On the sequencer's output-enable it snapshots all sums into a read bank that the neuron datapath reads one neuron at a time. Clearing between layers and time steps is driven by `ac_reset`.

## Interface
- `N_NEU`, 64: postsynaptic neurons (accumulators); power of two.
- `W_BITS`, 8: signed weight width.
- `ACC_BITS`, 16: signed accumulator width; must be ≥ `W_BITS`+1.
- `clk` input 1: single clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low; clears all state while low.
- `ac_reset` input 1: synchronous clear of the sums, the pending stage and `ac_ovf`.
- `ac_oen` input 1: snapshot the sums into the read bank.
- `acc_en` input 1: the current `w_word`/`spk_word`/`spk_switch` form a valid sample.
- `w_word` input `N_NEU*W_BITS`: packed weights; neuron i at bits [i*W_BITS +: W_BITS], two's complement.
- `spk_word` input 8: spike byte from spike memory.
- `spk_switch` input 3: selects the presynaptic bit `spk_word[spk_switch]`.
- `u_in_select` input log2(`N_NEU`): neuron index for readout.
- `ac_out` output `ACC_BITS`: snapshot value of the selected neuron, registered.
- `ac_ovf` output 1: sticky flag; set when any accumulator or snapshot sum overflowed since the last clear.

## Operation
- Stage 1 (sample): each edge registers `s1_v` <= `acc_en`, `s1_spk` <= `spk_word[spk_switch]`, `s1_w` <= `w_word`.
- Stage 2 (accumulate): if `s1_v` & `s1_spk`, every `acc[i]` <= `acc[i]` + sign-extended `s1_w[i]`. Otherwise the sums hold.
- Per-neuron arithmetic is done in `ACC_BITS`+1 bits.
  - Overflow occurs when the result falls outside [-2^(ACC_BITS-1), 2^(ACC_BITS-1)-1].
  - Overflow on any neuron sets `ac_ovf`. The stored value then depends on the configuration below.
- Snapshot: when `ac_oen`=1, every `snap[i]` <= the value `acc[i]` takes at that same edge, including the pending stage-2 add, with the same overflow rule. The snapshot holds until the next `ac_oen`.
- Clear: when `ac_reset`=1, `acc[i]` <= 0 for all i, the pending stage-2 add is discarded, and `ac_ovf` <= 0.
  - The sample presented in the same cycle is still captured into stage 1 (`s1_v` <= `acc_en`). The first weight of a new layer is therefore not lost.
- Simultaneous `ac_oen`=1 and `ac_reset`=1: the snapshot captures the pre-clear sum, including the pending add, and `acc` clears. This is the required layer-boundary behaviour.
- `ac_reset` has priority over the stage-2 add for `acc`. It does not affect `snap`.
- Readout: each edge, `ac_out` <= `snap[u_in_select]`. The output is unaffected by `acc_en`.
- `reset`=0 (asynchronous): `acc`, `snap`, `s1_v`, `s1_spk`, `s1_w`, `ac_out` and `ac_ovf` all go to 0 immediately. An in-flight accumulation is lost, with no partial update.

## Timing
- A sample accepted at edge k (`acc_en`=1) is reflected in `acc` after edge k+1.
- A snapshot at edge k+1 includes it; a snapshot at edge k does not.
- `ac_oen` at edge k makes the value visible on `ac_out` after edge k+1 for a steady `u_in_select`. That is 1 cycle of readout latency.
- `u_in_select` change at edge k: `ac_out` shows the new neuron after edge k.
- Throughput: one sample per cycle, with no stalls and no back-pressure.
- All outputs reset to 0.

## Configuration
- `ACC_SATURATE_EN` defined: on overflow, the stored sum or snapshot clamps to +2^(ACC_BITS-1)-1 or -2^(ACC_BITS-1) according to the true sign.
- Not defined: the result wraps (two's complement, low `ACC_BITS` bits are kept).
- `ac_ovf` behaves identically in both builds.

## Test plan
- Basic accumulate (N_NEU=64, W_BITS=8, ACC_BITS=16):
  - Stimulus: all weights = +3, `spk_word`=8'h01, `spk_switch`=0, `acc_en`=1 for 10 cycles, then `ac_oen`.
  - Required: `ac_out`=30 for every `u_in_select` 0..63; `ac_ovf`=0.
- Spike gating:
  - Stimulus: `spk_word`=8'b1010_1010, `spk_switch` cycling 0..7 with weight +1.
  - Required: snapshot = 4. A parallel run with `acc_en`=0 gives 0.
- Layer boundary:
  - Stimulus: neuron 5 weight -7 for 4 samples, then `ac_oen`+`ac_reset` together in the cycle after the last sample, with a new sample (+2) presented in that same cycle, then `ac_oen`.
  - Required: first snapshot = -28; second snapshot = +2.
- Overflow:
  - Stimulus: weight +127 for 300 samples.
  - Required with `ACC_SATURATE_EN`: `ac_out`=32767 and `ac_ovf`=1.
  - Required without it: `ac_out`=(300*127) mod 2^16 as signed (= -27436) and `ac_ovf`=1.
  - A following `ac_reset` clears `ac_ovf`.
- Async reset mid-accumulation:
  - Stimulus: assert `reset`=0 between edges after 5 samples.
  - Required: `ac_out` and `ac_ovf` go to 0 before the next edge. After release, a snapshot with no samples reads 0.
- Readout latency:
  - Stimulus: snapshot values set to i*2 per neuron, then sweep `u_in_select` 0..63 one per cycle.
  - Required: `ac_out` equals 2*`u_in_select` as sampled at the previous edge.

Source files
------------

// File: rtl/accumulator_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : accumulator_bank                                                |
// | Purpose  : Spike-gated per-neuron weight accumulators with snapshot bank   |
// |            and registered per-neuron readout.                              |
// | Options  : ACC_SATURATE_EN defined -> overflowing sums clamp; else wrap.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module accumulator_bank #(
  parameter int N_NEU    = 64,
  parameter int W_BITS   = 8,
  parameter int ACC_BITS = 16,
  localparam int SEL_BITS = (N_NEU > 1) ? $clog2(N_NEU) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ac_reset,
  input  logic                      ac_oen,
  input  logic                      acc_en,
  input  logic [N_NEU*W_BITS-1:0]   w_word,
  input  logic [7:0]                spk_word,
  input  logic [2:0]                spk_switch,
  input  logic [SEL_BITS-1:0]       u_in_select,
  output logic [ACC_BITS-1:0]       ac_out,
  output logic                      ac_ovf
);

  localparam logic [ACC_BITS-1:0] ACC_MAX = {1'b0, {(ACC_BITS-1){1'b1}}};
  localparam logic [ACC_BITS-1:0] ACC_MIN = {1'b1, {(ACC_BITS-1){1'b0}}};

  logic                            s1_v;
  logic                            s1_spk;
  logic [N_NEU*W_BITS-1:0]         s1_w;
  logic                            add_en;

  logic [ACC_BITS-1:0]             acc  [N_NEU];
  logic [ACC_BITS-1:0]             snap [N_NEU];
  logic [N_NEU-1:0][ACC_BITS-1:0]  nxt;
  logic [N_NEU-1:0]                ovf_vec;

  assign add_en = s1_v & s1_spk;

  // nxt[i] is the post-add value of acc[i]; both acc and snap load from it so
  // a snapshot always includes the add that is pending in the same cycle.
  for (genvar i = 0; i < N_NEU; i++) begin : g_neu
    logic [ACC_BITS:0] acc_ext;
    logic [ACC_BITS:0] addend;
    logic [ACC_BITS:0] sum;

    assign acc_ext = {acc[i][ACC_BITS-1], acc[i]};
    assign addend  = add_en
                   ? {{(ACC_BITS+1-W_BITS){s1_w[i*W_BITS+W_BITS-1]}}, s1_w[i*W_BITS +: W_BITS]}
                   : '0;
    assign sum        = acc_ext + addend;
    assign ovf_vec[i] = sum[ACC_BITS] ^ sum[ACC_BITS-1];

`ifdef ACC_SATURATE_EN
    assign nxt[i] = ovf_vec[i] ? (sum[ACC_BITS] ? ACC_MIN : ACC_MAX) : sum[ACC_BITS-1:0];
`else
    assign nxt[i] = sum[ACC_BITS-1:0];
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_v   <= 1'b0;
      s1_spk <= 1'b0;
      s1_w   <= '0;
      for (int i = 0; i < N_NEU; i++) begin
        acc[i]  <= '0;
        snap[i] <= '0;
      end
      ac_out <= '0;
      ac_ovf <= 1'b0;
    end else begin
      // Stage 1 keeps sampling during ac_reset so a new layer's first weight survives.
      s1_v   <= acc_en;
      s1_spk <= spk_word[spk_switch];
      s1_w   <= w_word;
      for (int i = 0; i < N_NEU; i++) begin
        acc[i] <= ac_reset ? '0 : nxt[i];
        if (ac_oen) begin
          snap[i] <= nxt[i];
        end
      end
      ac_out <= snap[u_in_select];
      if (ac_reset) begin
        ac_ovf <= 1'b0;
      end else if (|ovf_vec) begin
        ac_ovf <= 1'b1;
      end
    end
  end

endmodule
`default_nettype wire
